// File: rtl/goertzel_tone_analyzer_pkg.sv
// Shared definitions for the tone-measurement blocks: FSM encoding, Q-format
// constant and the signed saturating width reduction.
package goertzel_tone_analyzer_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ACCUM = 3'd1,
        ST_FIN1  = 3'd2,
        ST_FIN2  = 3'd3,
        ST_FIN3  = 3'd4,
        ST_FIN4  = 3'd5,
        ST_DONE  = 3'd6
    } state_t;

    // Fractional bits of the Q2.15 coefficient 2cos(2*pi*k/N).
    localparam int COEF_FRAC = 15;

    // Widest value the saturate helper accepts; callers sign-extend into it.
    localparam int SAT_MAX_W = 128;

    // Clamp a signed value to the signed range of 'width' bits; 'hit' flags a clamp.
    function automatic logic signed [SAT_MAX_W-1:0] saturate(
        input  logic signed [SAT_MAX_W-1:0] value,
        input  int                          width,
        output logic                        hit
    );
        logic signed [SAT_MAX_W-1:0] hi;
        logic signed [SAT_MAX_W-1:0] lo;
        logic signed [SAT_MAX_W-1:0] res;
        hi  = (SAT_MAX_W'(1) <<< (width - 1)) - SAT_MAX_W'(1);
        lo  = ~hi;
        hit = 1'b0;
        res = value;
        if (value > hi) begin
            hit = 1'b1;
            res = hi;
        end else if (value < lo) begin
            hit = 1'b1;
            res = lo;
        end
        return res;
    endfunction

endpackage

// File: rtl/goertzel_tone_analyzer_mac.sv
// Shared arithmetic path: multiply, optional arithmetic Q-shift, add/subtract
// and saturation, plus the registered power accumulator used in the FIN states.
module goertzel_mac
    import goertzel_tone_analyzer_pkg::*;
#(
    parameter int ACC_WIDTH   = 40,
    parameter int OPA_WIDTH   = 58,
    parameter int POWER_WIDTH = 82,
    parameter int FRAC_BITS   = 15
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic signed [OPA_WIDTH-1:0]   op_a,
    input  logic signed [ACC_WIDTH-1:0]   op_b,
    input  logic signed [POWER_WIDTH-1:0] addend,
    input  logic                          shift_en,
    input  logic                          subtract,
    input  logic                          use_acc,
    input  logic                          acc_en,
    output logic signed [POWER_WIDTH-1:0] result,
    output logic signed [ACC_WIDTH-1:0]   result_sat,
    output logic                          sat_hit
);

    localparam int PROD_WIDTH = OPA_WIDTH + ACC_WIDTH;
    localparam int SUM_WIDTH  = PROD_WIDTH + 1;

    logic signed [PROD_WIDTH-1:0]  product;
    logic signed [PROD_WIDTH-1:0]  term;
    logic signed [SUM_WIDTH-1:0]   base;
    logic signed [SUM_WIDTH-1:0]   sum;
    logic signed [POWER_WIDTH-1:0] acc;

    // The sum is kept one bit wider than the full product so add/sub never wraps
    // before saturation looks at it.
    always_comb begin
        product    = PROD_WIDTH'(op_a) * PROD_WIDTH'(op_b);
        term       = shift_en ? (product >>> FRAC_BITS) : product;
        base       = use_acc ? SUM_WIDTH'(acc) : SUM_WIDTH'(addend);
        sum        = subtract ? (base - SUM_WIDTH'(term)) : (base + SUM_WIDTH'(term));
        result     = POWER_WIDTH'(sum);
        result_sat = ACC_WIDTH'(saturate(SAT_MAX_W'(sum), ACC_WIDTH, sat_hit));
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc <= '0;
        end else if (acc_en) begin
            acc <= result;
        end
    end

endmodule

// File: rtl/goertzel_tone_analyzer.sv
// Single-bin Goertzel energy meter: runs the recursion over BLOCK_LEN accepted
// samples, then evaluates s1^2 + s2^2 - coef*s1*s2 over four shared-MAC cycles.
module goertzel_tone_analyzer
    import goertzel_tone_analyzer_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int COEF_WIDTH = 18,
    parameter int COEF_FRAC  = goertzel_tone_analyzer_pkg::COEF_FRAC,
    parameter int ACC_WIDTH  = 40,
    parameter int BLOCK_LEN  = 1024,
    localparam int CNT_WIDTH   = $clog2(BLOCK_LEN),
    localparam int POWER_WIDTH = 2 * ACC_WIDTH + 2
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic signed [COEF_WIDTH-1:0]  coef,
    input  logic                          sample_valid,
    input  logic signed [DATA_WIDTH-1:0]  sample_in,
    output logic                          sample_ready,
    output logic                          busy,
    output logic                          power_valid,
    output logic signed [POWER_WIDTH-1:0] power_out,
    output logic                          ovf,
    output state_t                        dbg_state
);

    // Handshake: a sample transfers on a rising clk edge where sample_valid and
    // sample_ready are both high; sample_ready is registered and high only in
    // ACCUM, so valid in any other state is simply ignored.

    localparam int OPA_WIDTH = ACC_WIDTH + COEF_WIDTH;
    localparam logic [CNT_WIDTH-1:0] LAST_CNT = CNT_WIDTH'(BLOCK_LEN - 1);

    state_t                        state;
    logic signed [ACC_WIDTH-1:0]   s1;
    logic signed [ACC_WIDTH-1:0]   s2;
    logic [CNT_WIDTH-1:0]          cnt;
    logic signed [COEF_WIDTH-1:0]  coef_r;
    logic signed [OPA_WIDTH-1:0]   t_r;

    logic signed [OPA_WIDTH-1:0]   op_a;
    logic signed [ACC_WIDTH-1:0]   op_b;
    logic signed [POWER_WIDTH-1:0] addend;
    logic                          shift_en;
    logic                          subtract;
    logic                          use_acc;
    logic                          acc_en;
    logic signed [POWER_WIDTH-1:0] mac_result;
    logic signed [ACC_WIDTH-1:0]   mac_sat;
    logic                          mac_sat_hit;

    assign dbg_state = state;

    // One MAC operation per state: recursion step in ACCUM, power terms in FIN1-4.
    always_comb begin
        op_a     = OPA_WIDTH'(coef_r);
        op_b     = s1;
        addend   = '0;
        shift_en = 1'b0;
        subtract = 1'b0;
        use_acc  = 1'b0;
        acc_en   = 1'b0;
        case (state)
            ST_ACCUM: begin
                shift_en = 1'b1;
                addend   = POWER_WIDTH'(sample_in) - POWER_WIDTH'(s2);
            end
            ST_FIN1: begin
                op_a   = OPA_WIDTH'(s1);
                acc_en = 1'b1;
            end
            ST_FIN2: begin
                op_a    = OPA_WIDTH'(s2);
                op_b    = s2;
                use_acc = 1'b1;
                acc_en  = 1'b1;
            end
            ST_FIN3: begin
                shift_en = 1'b1;
            end
            ST_FIN4: begin
                op_a     = t_r;
                op_b     = s2;
                use_acc  = 1'b1;
                subtract = 1'b1;
                acc_en   = 1'b1;
            end
            default: ;
        endcase
    end

    goertzel_mac #(
        .ACC_WIDTH  (ACC_WIDTH),
        .OPA_WIDTH  (OPA_WIDTH),
        .POWER_WIDTH(POWER_WIDTH),
        .FRAC_BITS  (COEF_FRAC)
    ) u_mac (
        .clk       (clk),
        .rst       (rst),
        .op_a      (op_a),
        .op_b      (op_b),
        .addend    (addend),
        .shift_en  (shift_en),
        .subtract  (subtract),
        .use_acc   (use_acc),
        .acc_en    (acc_en),
        .result    (mac_result),
        .result_sat(mac_sat),
        .sat_hit   (mac_sat_hit)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state        <= ST_IDLE;
            s1           <= '0;
            s2           <= '0;
            cnt          <= '0;
            coef_r       <= '0;
            t_r          <= '0;
            power_out    <= '0;
            power_valid  <= 1'b0;
            ovf          <= 1'b0;
            sample_ready <= 1'b0;
            busy         <= 1'b0;
        end else begin
            power_valid <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        coef_r       <= coef;
                        s1           <= '0;
                        s2           <= '0;
                        cnt          <= '0;
                        ovf          <= 1'b0;
                        sample_ready <= 1'b1;
                        busy         <= 1'b1;
                        state        <= ST_ACCUM;
                    end
                end
                ST_ACCUM: begin
                    if (sample_valid) begin
                        s2  <= s1;
                        s1  <= mac_sat;
                        ovf <= ovf | mac_sat_hit;
                        cnt <= cnt + 1'b1;
                        if (cnt == LAST_CNT) begin
                            sample_ready <= 1'b0;
                            state        <= ST_FIN1;
                        end
                    end
                end
                ST_FIN1: state <= ST_FIN2;
                ST_FIN2: state <= ST_FIN3;
                ST_FIN3: begin
                    t_r   <= OPA_WIDTH'(mac_result);
                    state <= ST_FIN4;
                end
                // The final power is visible (with the pulse) for the whole DONE cycle.
                ST_FIN4: begin
                    power_out   <= mac_result;
                    power_valid <= 1'b1;
                    state       <= ST_DONE;
                end
                ST_DONE: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    sample_ready <= 1'b0;
                    busy         <= 1'b0;
                    state        <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_goertzel_tone_analyzer.sv
// Bench for goertzel_tone_analyzer: two instances (wide and narrow accumulator)
// share stimulus; results are scored against a plain-arithmetic Goertzel model.
module tb_goertzel_tone_analyzer;
    import goertzel_tone_analyzer_pkg::*;

    logic               clk;
    logic               rst;
    logic               start;
    logic signed [17:0] coef;
    logic               sample_valid;
    logic signed [31:0] sample_in;

    logic               sample_ready;
    logic               busy;
    logic               power_valid;
    logic signed [81:0] power_out;
    logic               ovf;
    state_t             dbg_state;

    logic               sat_ready;
    logic               sat_busy;
    logic               sat_valid;
    logic signed [41:0] sat_power;
    logic               sat_ovf;
    state_t             sat_state;

    int n_tests;
    int n_fail;
    int pv_count;
    int blocks_run;
    int ready_err;

    logic [127:0] exp_q[$];
    logic [127:0] exp_sat_q[$];
    logic         exp_ovf_q[$];
    logic         exp_sat_ovf_q[$];

    logic signed [31:0]  blk[4];
    logic signed [127:0] last_s1;
    logic signed [127:0] last_s2;

    goertzel_tone_analyzer #(.ACC_WIDTH(40), .BLOCK_LEN(4)) dut (
        .clk(clk), .rst(rst), .start(start), .coef(coef),
        .sample_valid(sample_valid), .sample_in(sample_in),
        .sample_ready(sample_ready), .busy(busy), .power_valid(power_valid),
        .power_out(power_out), .ovf(ovf), .dbg_state(dbg_state)
    );

    goertzel_tone_analyzer #(.ACC_WIDTH(20), .BLOCK_LEN(4)) dut_sat (
        .clk(clk), .rst(rst), .start(start), .coef(coef),
        .sample_valid(sample_valid), .sample_in(sample_in),
        .sample_ready(sat_ready), .busy(sat_busy), .power_valid(sat_valid),
        .power_out(sat_power), .ovf(sat_ovf), .dbg_state(sat_state)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: bench did not reach its summary");
        $fatal(1, "timeout");
    end

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", tag, $signed(got), $signed(exp));
        end
    endtask

    // Reference: Goertzel recursion with saturation to 'aw' bits, then the power formula.
    task automatic model_block(input logic signed [17:0] c, input int aw,
                               output logic signed [127:0] pw, output logic ov,
                               output logic signed [127:0] f1, output logic signed [127:0] f2);
        logic signed [127:0] s1, s2, sn, hi, lo, t;
        hi = (128'sd1 <<< (aw - 1)) - 128'sd1;
        lo = -hi - 128'sd1;
        s1 = 0;
        s2 = 0;
        ov = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sn = blk[i] + ((c * s1) >>> 15) - s2;
            if (sn > hi) begin
                sn = hi;
                ov = 1'b1;
            end else if (sn < lo) begin
                sn = lo;
                ov = 1'b1;
            end
            s2 = s1;
            s1 = sn;
        end
        t  = (c * s1) >>> 15;
        pw = s1 * s1 + s2 * s2 - t * s2;
        f1 = s1;
        f2 = s2;
    endtask

    // scoreboard: every power_valid pulse must match the oldest queued expectation
    always @(negedge clk) begin
        if (rst && power_valid) begin
            pv_count++;
            check("pv_expected", 128'(exp_q.size() > 0), 128'(1));
            if (exp_q.size() > 0) begin
                check("power", power_out, exp_q.pop_front());
                check("ovf", ovf, exp_ovf_q.pop_front());
            end
        end
        if (rst && sat_valid) begin
            check("sat_pv_expected", 128'(exp_sat_q.size() > 0), 128'(1));
            if (exp_sat_q.size() > 0) begin
                check("sat_power", sat_power, exp_sat_q.pop_front());
                check("sat_ovf", sat_ovf, exp_sat_ovf_q.pop_front());
            end
        end
        if (rst && ((sample_ready != (dbg_state == ST_ACCUM)) || (busy != (dbg_state != ST_IDLE))))
            ready_err++;
    end

    // driver: one block of blk[] with optional gaps, mid-block start and post-block valid
    task automatic run_block(input logic signed [17:0] c, input int gap_mode,
                             input bit mid_start, input bit hold_valid);
        logic signed [127:0] pw, f1, f2;
        logic                ov;
        int                  gap;
        int                  lat;
        model_block(c, 40, pw, ov, f1, f2);
        exp_q.push_back(pw);
        exp_ovf_q.push_back(ov);
        last_s1 = f1;
        last_s2 = f2;
        model_block(c, 20, pw, ov, f1, f2);
        exp_sat_q.push_back(pw);
        exp_sat_ovf_q.push_back(ov);
        blocks_run++;

        @(negedge clk);
        coef  = c;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        coef  = 18'($urandom);
        check("start_busy", busy, 1);
        check("start_ready", sample_ready, 1);
        check("start_ovf_clr", sat_ovf, 0);

        for (int i = 0; i < 4; i++) begin
            gap = (gap_mode == 0) ? 0 : (gap_mode == 1) ? 1 : $urandom_range(0, 3);
            repeat (gap) begin
                sample_valid = 1'b0;
                sample_in    = $urandom;
                @(negedge clk);
            end
            sample_valid = 1'b1;
            sample_in    = blk[i];
            if (mid_start && i == 2) start = 1'b1;
            @(negedge clk);
            start = 1'b0;
        end

        sample_valid = hold_valid;
        sample_in    = $urandom;
        check("fin_ready_low", sample_ready, 0);
        lat = 1;
        while (!power_valid && lat < 20) begin
            @(negedge clk);
            sample_in = $urandom;
            lat++;
        end
        check("latency", lat, 5);
        @(negedge clk);
        sample_valid = 1'b0;
        check("pv_one_cycle", power_valid, 0);
        check("idle_after_done", busy, 0);
    endtask

    task automatic fill_const(input logic signed [31:0] v);
        for (int i = 0; i < 4; i++) blk[i] = v;
    endtask

    initial begin
        logic signed [17:0] c;
        int                 mode;
        n_tests      = 0;
        n_fail       = 0;
        pv_count     = 0;
        blocks_run   = 0;
        ready_err    = 0;
        rst          = 1'b0;
        start        = 1'b0;
        coef         = '0;
        sample_valid = 1'b0;
        sample_in    = '0;
        repeat (3) @(negedge clk);
        check("rst_power", power_out, 0);
        check("rst_pv", power_valid, 0);
        check("rst_ovf", ovf, 0);
        check("rst_ready", sample_ready, 0);
        check("rst_busy", busy, 0);
        rst = 1'b1;
        @(negedge clk);

        // bin k=1, coef 0: 1,0,-1,0
        blk[0] = 1; blk[1] = 0; blk[2] = -1; blk[3] = 0;
        run_block(18'sd0, 0, 1'b0, 1'b0);
        check("k1_power", power_out, 4);
        check("k1_s1", dut.s1, 0);
        check("k1_s2", dut.s2, -2);
        check("k1_ovf", ovf, 0);

        // DC bin, coef 2.0, back-to-back then with gaps
        fill_const(5);
        run_block(18'sd65536, 0, 1'b0, 1'b0);
        check("dc_power", power_out, 400);
        check("dc_s1", dut.s1, 50);
        check("dc_s2", dut.s2, 30);
        run_block(18'sd65536, 1, 1'b0, 1'b0);
        check("dc_alt_power", power_out, 400);
        run_block(18'sd65536, 2, 1'b0, 1'b0);
        check("dc_gap_power", power_out, 400);

        // stray start mid-block and valid held through FIN/DONE
        run_block(18'sd65536, 0, 1'b1, 1'b1);
        check("dc_mid_start_power", power_out, 400);

        // narrow accumulator saturates
        fill_const(100000);
        run_block(18'sd65536, 0, 1'b0, 1'b0);
        check("sat_flag", sat_ovf, 1);
        check("sat_s1_clamp", dut_sat.s1, 524287);
        check("wide_no_ovf", ovf, 0);
        check("wide_s1", dut.s1, last_s1);

        // reset mid-block discards everything
        fill_const(5);
        @(negedge clk);
        coef  = 18'sd65536;
        start = 1'b1;
        @(negedge clk);
        start        = 1'b0;
        sample_valid = 1'b1;
        sample_in    = 5;
        repeat (2) @(negedge clk);
        sample_valid = 1'b0;
        rst          = 1'b0;
        @(negedge clk);
        check("abort_power", power_out, 0);
        check("abort_busy", busy, 0);
        check("abort_ready", sample_ready, 0);
        rst = 1'b1;
        repeat (8) @(negedge clk);
        run_block(18'sd65536, 0, 1'b0, 1'b0);
        check("post_abort_power", power_out, 400);

        // randomized blocks
        for (int b = 0; b < 24; b++) begin
            for (int i = 0; i < 4; i++) begin
                mode = $urandom_range(0, 2);
                if (mode == 0)      blk[i] = $urandom_range(0, 2000) - 1000;
                else if (mode == 1) blk[i] = 32'(signed'(20'($urandom)));
                else                blk[i] = $urandom;
            end
            c = 18'($urandom);
            run_block(c, $urandom_range(0, 2), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            check("rand_s1", dut.s1, last_s1);
            check("rand_s2", dut.s2, last_s2);
        end

        repeat (4) @(negedge clk);
        check("pulse_count", pv_count, blocks_run);
        check("queue_drained", exp_q.size() + exp_sat_q.size(), 0);
        check("ready_iff_accum", ready_err, 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
